// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake bundle between a requester and the ALU sequencer.
interface alu_op_sequencer_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned OPW   = 2
);
  logic             req_valid;
  logic             req_ready;
  logic [OPW-1:0]   req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_setcc;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_flag;

  // Requester / response consumer side
  modport master (
    output req_valid, req_op, req_a, req_b, req_setcc, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flag
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_setcc, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flag
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Initiator for the combinational ALU: accepts an op, holds the operands on the
// ALU for one evaluation cycle, captures the result/flag, returns it over a
// valid/ready response and optionally updates the ZF/SF/OF condition codes.
module alu_op_sequencer #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned OPW   = 2
) (
  input  logic             clk,
  input  logic             rst,
  alu_op_sequencer_if.slave bus,
  output logic [OPW-1:0]   alu_operation_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  input  logic [WIDTH-1:0] alu_out_i,
  input  logic             alu_flag_i,
  output logic             cc_zf_o,
  output logic             cc_sf_o,
  output logic             cc_of_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             setcc_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_flag_q;
  logic             rsp_valid_q;
  logic             zf_q;
  logic             sf_q;
  logic             of_q;
  logic             zf_d;
  logic             sf_d;
  logic             of_d;
  logic             accept;

  // Ready in IDLE, or in RESP when the response is being taken this cycle
  assign bus.req_ready = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;

  assign alu_operation_o = op_q;
  assign alu_a_o         = a_q;
  assign alu_b_o         = b_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_flag    = rsp_flag_q;
  assign cc_zf_o         = zf_q;
  assign cc_sf_o         = sf_q;
  assign cc_of_o         = of_q;
  assign busy_o          = (state_q != IDLE);

  // Condition codes the current ALU result would produce; logical ops clear OF
  always_comb begin
    zf_d = zf_q;
    sf_d = sf_q;
    of_d = of_q;
    if (setcc_q) begin
      zf_d = (alu_out_i == '0);
      sf_d = alu_out_i[WIDTH-1];
      of_d = op_q[1] ? 1'b0 : alu_flag_i;
    end
  end

  // Sequencer FSM with registered ALU operands, response and condition codes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      setcc_q      <= 1'b0;
      rsp_result_q <= '0;
      rsp_flag_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      zf_q         <= 1'b1;
      sf_q         <= 1'b0;
      of_q         <= 1'b0;
    end else begin
      // Operands move only on acceptance, from IDLE or back-to-back from RESP
      if (accept) begin
        op_q    <= bus.req_op;
        a_q     <= bus.req_a;
        b_q     <= bus.req_b;
        setcc_q <= bus.req_setcc;
      end
      case (state_q)
        IDLE: begin
          if (accept) state_q <= EXEC;
        end
        EXEC: begin
          rsp_result_q <= alu_out_i;
          rsp_flag_q   <= alu_flag_i;
          zf_q         <= zf_d;
          sf_q         <= sf_d;
          of_q         <= of_d;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= accept ? EXEC : IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule
